bp_sacc_he_enc_sequencer: RTL and testbench

- Sequences one polynomial encryption pass through the HE encryption core inside the sacc accelerator tile.
- Streams N coefficient tuples (u, e1, m+e0, pk0, pk1) from the input scratchpads into the core over a valid/ready handshake.
- Writes the core's cipher0/cipher1 outputs back to the result scratchpad, then raises done for the CSR block.
- Sits between the CSR/IO decode logic (start, length, done) and the core plus its SPMs.

---
 rtl/bp_sacc_he_pkg.sv | 36 +++
 rtl/bp_sacc_he_enc_sequencer_fifo.sv | 63 ++++++
 rtl/bp_sacc_he_enc_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_bp_sacc_he_enc_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_sacc_he_pkg.sv
// Shared definitions for the sacc HE encryption path.
// Holds the sequencer state type, the packed coefficient tuple layout and the
// ring constants, so the encryption core and its sequencer agree on them.
package bp_sacc_he_pkg;

    localparam int he_logq_p = 30;
    localparam int he_logn_p = 12;
    localparam int he_n_p    = 4096;

    // q = 2^30 - 2^18 + 1 (NTT-friendly, q-1 divisible by 2N)
    localparam logic [29:0] he_q_p     = 30'd1073479681;
    // N_inv = q - (q-1)/N, i.e. N * N_inv == 1 (mod q)
    localparam logic [29:0] he_n_inv_p = 30'd1073217601;

    typedef enum logic [1:0] {
        e_seq_idle  = 2'd0,
        e_seq_run   = 2'd1,
        e_seq_drain = 2'd2,
        e_seq_done  = 2'd3
    } bp_sacc_he_seq_state_e;

    // Packed MSB-first, so the flat bus reads {pk1,pk0,me0,e1,u}
    typedef struct packed {
        logic [he_logq_p-1:0] pk1;
        logic [he_logq_p-1:0] pk0;
        logic [he_logq_p-1:0] me0;
        logic [he_logq_p-1:0] e1;
        logic [he_logq_p-1:0] u;
    } bp_sacc_he_tuple_s;

    // ceil(log2(n)), but never below 1 so degenerate sizes still get a bit
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bp_sacc_he_enc_sequencer_fifo.sv
// Two-entry FIFO holding coefficient tuples between the SPM read return and
// the encryption core.
// Ports:
//   clk_i, reset_ni  clock, asynchronous active-low reset
//   enq_i, data_i    write one entry (caller guarantees not full)
//   deq_i            pop the head (caller guarantees not empty)
//   data_o           head entry
//   count_o          occupancy, 0..2
module bp_sacc_he_enc_sequencer_fifo #(
    parameter int width_p = 150
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               enq_i,
    input  logic [width_p-1:0] data_i,
    input  logic               deq_i,
    output logic [width_p-1:0] data_o,
    output logic [1:0]         count_o
);

    logic [1:0][width_p-1:0] mem_q, mem_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {1'b0, enq_i} - {1'b0, deq_i};
        if (enq_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (deq_i) begin
            rd_ptr_d = !rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Upstream credit accounting must make these unreachable
    a_no_enq_full : assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(enq_i && (count_q == 2'd2)));
    a_no_deq_empty : assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(deq_i && (count_q == 2'd0)));

endmodule

// File: rtl/bp_sacc_he_enc_sequencer.sv
// Sequencer for one polynomial encryption pass of the sacc HE core.
// Reads len coefficient tuples from the input SPMs, streams them into the
// core over valid/ready, writes {cipher1,cipher0} back to the result SPM and
// raises a sticky done flag for the CSR block.
// Ports:
//   start_i/len_i/clear_i      CSR control; busy_o/done_o/err_o status
//   rd_v_o/rd_addr_o/rd_data_i input SPM read (data one cycle after strobe)
//   core_v_o/core_data_o/core_ready_i        tuple stream into the core
//   core_out_v_i/cipher*_i/core_out_ready_o  result stream from the core
//   wr_v_o/wr_addr_o/wr_data_o               result SPM write
//
// state | meaning
// IDLE  | waiting for start_i; len==0 jumps straight to DONE
// RUN   | issuing reads and feeding the core; results may already return
// DRAIN | all tuples delivered, waiting for the remaining results
// DONE  | one cycle; sets the sticky done flag, then back to IDLE
module bp_sacc_he_enc_sequencer
    import bp_sacc_he_pkg::*;
#(
    parameter int  coef_width_p  = he_logq_p,
    parameter int  els_p         = he_n_p,
    localparam int addr_width_lp = safe_clog2(els_p),
    localparam int len_width_lp  = safe_clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      start_i,
    input  logic [len_width_lp-1:0]   len_i,
    input  logic                      clear_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      rd_v_o,
    output logic [addr_width_lp-1:0]  rd_addr_o,
    input  logic [5*coef_width_p-1:0] rd_data_i,
    output logic                      core_v_o,
    output logic [5*coef_width_p-1:0] core_data_o,
    input  logic                      core_ready_i,
    input  logic                      core_out_v_i,
    input  logic [coef_width_p-1:0]   cipher0_i,
    input  logic [coef_width_p-1:0]   cipher1_i,
    output logic                      core_out_ready_o,
    output logic                      wr_v_o,
    output logic [addr_width_lp-1:0]  wr_addr_o,
    output logic [2*coef_width_p-1:0] wr_data_o
);

    localparam int tuple_width_lp = 5 * coef_width_p;
    localparam logic [len_width_lp-1:0] els_lp = len_width_lp'(els_p);

    bp_sacc_he_seq_state_e state_q, state_d;

    logic [len_width_lp-1:0]   len_q, len_d;
    logic [len_width_lp-1:0]   rd_idx_q, rd_idx_d;
    logic [len_width_lp-1:0]   wr_idx_q, wr_idx_d;
    logic                      inflight_q, inflight_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic [len_width_lp-1:0]   len_clamped;
    logic                      busy;
    logic                      fifo_empty, fifo_enq, fifo_deq;
    logic [1:0]                fifo_count;
    logic [tuple_width_lp-1:0] fifo_head;
    logic                      core_fire, rd_issue, wr_fire, out_unexpected;
    logic [2:0]                slots_used;

    assign busy       = (state_q == e_seq_run) || (state_q == e_seq_drain);
    assign fifo_empty = (fifo_count == 2'd0);

    // A returning read is offered to the core in the same cycle when the FIFO
    // is empty; it is only written into the FIFO if the core does not take it.
    // This gives first valid two cycles after start and keeps the held tuple
    // stable across a stall (it becomes the FIFO head).
    assign core_v_o    = !fifo_empty || inflight_q;
    assign core_data_o = !fifo_empty ? fifo_head : (inflight_q ? rd_data_i : '0);
    assign core_fire   = core_v_o && core_ready_i;
    assign fifo_deq    = core_fire && !fifo_empty;
    assign fifo_enq    = inflight_q && !(fifo_empty && core_ready_i);

    // Slots still committed after this cycle's hand-off; counting the
    // departing tuple lets reads issue back-to-back under continuous ready.
    assign slots_used = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, core_fire};
    assign rd_issue   = (state_q == e_seq_run) && (rd_idx_q < len_q) && (slots_used < 3'd2);

    assign out_unexpected = core_out_v_i && (!busy || (wr_idx_q == len_q));
    assign wr_fire        = core_out_v_i && busy && (wr_idx_q != len_q);

    assign len_clamped = (len_i > els_lp) ? els_lp : len_i;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_idx_d   = rd_idx_q;
        wr_idx_d   = wr_idx_q;
        inflight_d = rd_issue;
        done_d     = done_q;
        err_d      = err_q;

        if (clear_i) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end
        if (out_unexpected) begin
            err_d = 1'b1;
        end
        if (rd_issue) begin
            rd_idx_d = rd_idx_q + len_width_lp'(1);
        end
        if (wr_fire) begin
            wr_idx_d = wr_idx_q + len_width_lp'(1);
        end

        case (state_q)
            e_seq_idle: begin
                if (start_i) begin
                    len_d    = len_clamped;
                    rd_idx_d = '0;
                    wr_idx_d = '0;
                    done_d   = 1'b0;
                    state_d  = (len_clamped == '0) ? e_seq_done : e_seq_run;
                end
            end
            e_seq_run: begin
                if ((rd_idx_q == len_q) && !inflight_q && fifo_empty) begin
                    state_d = e_seq_drain;
                end
            end
            e_seq_drain: begin
                if (wr_idx_q == len_q) begin
                    state_d = e_seq_done;
                end
            end
            e_seq_done: begin
                done_d  = 1'b1;
                state_d = e_seq_idle;
            end
            default: begin
                state_d = e_seq_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= e_seq_idle;
            len_q      <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    bp_sacc_he_enc_sequencer_fifo #(
        .width_p (tuple_width_lp)
    ) u_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .enq_i    (fifo_enq),
        .data_i   (rd_data_i),
        .deq_i    (fifo_deq),
        .data_o   (fifo_head),
        .count_o  (fifo_count)
    );

    assign busy_o           = busy;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign rd_v_o           = rd_issue;
    assign rd_addr_o        = rd_idx_q[addr_width_lp-1:0];
    assign core_out_ready_o = busy;
    assign wr_v_o           = wr_fire;
    assign wr_addr_o        = wr_idx_q[addr_width_lp-1:0];
    assign wr_data_o        = wr_fire ? {cipher1_i, cipher0_i} : '0;

endmodule

// File: tb/tb_bp_sacc_he_enc_sequencer.sv
// Directed bench for bp_sacc_he_enc_sequencer with an SPM model (data one
// cycle after the read strobe) and a fixed 3-cycle-latency core model.
module tb_bp_sacc_he_enc_sequencer;

    logic          clk_i = 1'b0;
    logic          reset_ni;
    logic          start_i;
    logic [12:0]   len_i;
    logic          clear_i;
    logic          busy_o, done_o, err_o;
    logic          rd_v_o;
    logic [11:0]   rd_addr_o;
    logic [149:0]  rd_data_i;
    logic          core_v_o;
    logic [149:0]  core_data_o;
    logic          core_ready_i;
    logic          core_out_v_i;
    logic [29:0]   cipher0_i, cipher1_i;
    logic          core_out_ready_o;
    logic          wr_v_o;
    logic [11:0]   wr_addr_o;
    logic [59:0]   wr_data_o;

    always #5 clk_i = ~clk_i;

    bp_sacc_he_enc_sequencer #(
        .coef_width_p (30),
        .els_p        (4096)
    ) dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .start_i          (start_i),
        .len_i            (len_i),
        .clear_i          (clear_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .rd_v_o           (rd_v_o),
        .rd_addr_o        (rd_addr_o),
        .rd_data_i        (rd_data_i),
        .core_v_o         (core_v_o),
        .core_data_o      (core_data_o),
        .core_ready_i     (core_ready_i),
        .core_out_v_i     (core_out_v_i),
        .cipher0_i        (cipher0_i),
        .cipher1_i        (cipher1_i),
        .core_out_ready_o (core_out_ready_o),
        .wr_v_o           (wr_v_o),
        .wr_addr_o        (wr_addr_o),
        .wr_data_o        (wr_data_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int s_cyc;
    logic        start_req = 1'b0;
    logic [12:0] len_req = '0;
    logic        clear_req = 1'b0;
    logic        spur_req = 1'b0;
    int          ready_pat = 0;

    logic        rd_pend = 1'b0;
    int          rd_pend_addr = 0;
    logic        stall_prev = 1'b0;
    logic [149:0] stall_data = '0;

    int          due_q[$];
    logic [29:0] c0_q[$];
    logic [29:0] c1_q[$];

    int   exp_rd, exp_wr, wr_cnt, first_rd, last_rd, first_v, last_wr, last_wr_addr, done_cyc;
    logic busy_seen, done_s, busy_s, err_s;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [149:0] spm_word(input int a);
        logic [149:0] w;
        w = '0;
        for (int k = 0; k < 5; k++) begin
            w[k*30 +: 30] = 30'((k + 1) << 24) + 30'(a * (k + 3));
        end
        return w;
    endfunction

    function automatic logic [59:0] he_ref(input logic [149:0] t);
        logic [29:0] u, e1, me0, pk0, pk1, c0, c1;
        u   = t[29:0];
        e1  = t[59:30];
        me0 = t[89:60];
        pk0 = t[119:90];
        pk1 = t[149:120];
        c0  = u + pk0 + me0;
        c1  = e1 ^ pk1;
        return {c1, c0};
    endfunction

    // One clock cycle: drive inputs at the falling edge, observe 1 time unit later
    task automatic step();
        logic        model_v;
        logic [59:0] r;
        start_i      = start_req;
        len_i        = len_req;
        clear_i      = clear_req;
        rd_data_i    = rd_pend ? spm_word(rd_pend_addr) : '0;
        core_ready_i = (ready_pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        model_v      = (due_q.size() != 0) && (due_q[0] <= cyc);
        core_out_v_i = spur_req || model_v;
        cipher0_i    = model_v ? c0_q[0] : 30'h15;
        cipher1_i    = model_v ? c1_q[0] : 30'h2a;
        #1;
        if (stall_prev) begin
            check_eq("stall_valid", core_v_o, 1);
            check_eq("stall_data", core_data_o == stall_data, 1);
        end
        stall_prev = core_v_o && !core_ready_i;
        stall_data = core_data_o;
        if (core_v_o && core_ready_i) begin
            r = he_ref(core_data_o);
            due_q.push_back(cyc + 3);
            c0_q.push_back(r[29:0]);
            c1_q.push_back(r[59:30]);
        end
        if (core_v_o && first_v < 0) first_v = cyc;
        if (rd_v_o) begin
            check_eq("rd_addr", rd_addr_o, exp_rd);
            exp_rd++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (wr_v_o) begin
            check_eq("wr_addr", wr_addr_o, exp_wr);
            check_eq("wr_data", wr_data_o, he_ref(spm_word(exp_wr)));
            exp_wr++;
            wr_cnt++;
            last_wr = cyc;
            last_wr_addr = wr_addr_o;
        end
        if (model_v && core_out_ready_o) begin
            void'(due_q.pop_front());
            void'(c0_q.pop_front());
            void'(c1_q.pop_front());
        end
        rd_pend      = rd_v_o;
        rd_pend_addr = rd_addr_o;
        if (busy_o) busy_seen = 1'b1;
        if (done_o && !done_s) done_cyc = cyc;
        done_s = done_o;
        busy_s = busy_o;
        err_s  = err_o;
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic start_pass(input int len);
        exp_rd = 0; exp_wr = 0; wr_cnt = 0;
        first_rd = -1; last_rd = -1; first_v = -1; last_wr = -1; done_cyc = -1;
        busy_seen = 1'b0;
        start_req = 1'b1;
        len_req   = 13'(len);
        s_cyc     = cyc;
        step();
        start_req = 1'b0;
        done_s    = 1'b0;
    endtask

    task automatic run_to_done(input int limit);
        for (int n = 0; n < limit && !done_s; n++) step();
        check_eq("done_seen", done_s, 1);
    endtask

    task automatic check_idle_outputs();
        check_eq("z_busy", busy_o, 0);
        check_eq("z_done", done_o, 0);
        check_eq("z_err", err_o, 0);
        check_eq("z_rd_v", rd_v_o, 0);
        check_eq("z_rd_addr", rd_addr_o, 0);
        check_eq("z_core_v", core_v_o, 0);
        check_eq("z_core_data", core_data_o == '0, 1);
        check_eq("z_out_ready", core_out_ready_o, 0);
        check_eq("z_wr_v", wr_v_o, 0);
        check_eq("z_wr_addr", wr_addr_o, 0);
        check_eq("z_wr_data", wr_data_o, 0);
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        due_q.delete(); c0_q.delete(); c1_q.delete();
        rd_pend = 1'b0; stall_prev = 1'b0; done_s = 1'b0;
        start_i = 1'b0; clear_i = 1'b0; core_out_v_i = 1'b0;
        rd_data_i = '0; cipher0_i = '0; cipher1_i = '0; core_ready_i = 1'b1; len_i = '0;
        #1;
        check_idle_outputs();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
    endtask

    initial begin
        reset_ni = 1'b1;
        @(negedge clk_i);
        do_reset();

        // len=4, continuous ready
        ready_pat = 0;
        start_pass(4);
        run_to_done(60);
        check_eq("t1_first_rd", first_rd - s_cyc, 1);
        check_eq("t1_last_rd", last_rd - s_cyc, 4);
        check_eq("t1_first_core_v", first_v - s_cyc, 2);
        check_eq("t1_rd_count", exp_rd, 4);
        check_eq("t1_wr_count", wr_cnt, 4);
        check_eq("t1_done_after_wr", done_cyc > last_wr, 1);
        check_eq("t1_busy_low", busy_s, 0);
        check_eq("t1_err", err_s, 0);

        // len=8, ready 1,0,0,1 repeating
        ready_pat = 1;
        start_pass(8);
        check_eq("t2_done_cleared", done_o, 0);
        run_to_done(200);
        check_eq("t2_rd_count", exp_rd, 8);
        check_eq("t2_wr_count", wr_cnt, 8);
        check_eq("t2_err", err_s, 0);
        ready_pat = 0;

        // len=0; clear in the DONE cycle must lose to the set
        start_pass(0);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check_eq("t3_busy", busy_s, 0);
        check_eq("t3_done_early", done_s, 0);
        step();
        check_eq("t3_done", done_s, 1);
        step();
        check_eq("t3_busy_seen", busy_seen, 0);
        check_eq("t3_rd_count", exp_rd, 0);
        check_eq("t3_wr_count", wr_cnt, 0);

        // len=6 with a second start (len=2) while busy
        start_pass(6);
        step(); step(); step();
        start_req = 1'b1;
        len_req   = 13'd2;
        step();
        start_req = 1'b0;
        run_to_done(100);
        check_eq("t4_rd_count", exp_rd, 6);
        check_eq("t4_wr_count", wr_cnt, 6);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        check_eq("t4_cleared", done_s, 0);

        // len=10, reset after the 3rd write, then len=1
        start_pass(10);
        for (int n = 0; n < 60 && wr_cnt < 3; n++) step();
        check_eq("t5_pre_wr", wr_cnt, 3);
        do_reset();
        start_pass(1);
        run_to_done(40);
        check_eq("t5_wr_count", wr_cnt, 1);
        check_eq("t5_last_addr", last_wr_addr, 0);
        check_eq("t5_err", err_s, 0);

        // len=4096, continuous ready, then a spurious result
        start_pass(4096);
        run_to_done(4300);
        check_eq("t6_rd_count", exp_rd, 4096);
        check_eq("t6_wr_count", wr_cnt, 4096);
        check_eq("t6_last_addr", last_wr_addr, 4095);
        check_eq("t6_err_before", err_s, 0);
        spur_req = 1'b1;
        step();
        spur_req = 1'b0;
        check_eq("t6_spur_no_wr", wr_cnt, 4096);
        step();
        check_eq("t6_spur_err", err_s, 1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        check_eq("t6_err_cleared", err_s, 0);

        // len above N is clamped to N
        start_pass(5000);
        run_to_done(4300);
        check_eq("t7_rd_count", exp_rd, 4096);
        check_eq("t7_wr_count", wr_cnt, 4096);
        check_eq("t7_err", err_s, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
